// File: rtl/tdm_mux_4x2_if.sv
// Bundles the per-channel load side and the demux-facing serial side of tdm_mux_4x2.
// master drives loads and enable; slave is the multiplexer itself.
interface tdm_mux_4x2_if;
    logic [3:0] a;
    logic [3:0] v;
    logic       en;
    logic       d;
    logic [1:0] x;
    logic       s;
    logic       busy;
    logic [3:0] ovf;

    modport master (
        output a, v, en,
        input  d, x, s, busy, ovf
    );

    modport slave (
        input  a, v, en,
        output d, x, s, busy, ovf
    );
endinterface

// File: rtl/tdm_mux_4x2.sv
// Four 1-bit channels time-multiplexed onto one serial bit (d, x, s), round-robin served.
// One-cycle load-to-strobe latency; no backpressure, a strobe into a full buffer is dropped and flagged in ovf.
module tdm_mux_4x2 (
    input  logic          clk,
    input  logic          rst,
    tdm_mux_4x2_if.slave  bus
);

    logic [3:0] pend_q, pend_d;
    logic [3:0] dat_q,  dat_d;
    logic [3:0] ovf_q,  ovf_d;
    logic       s_q,    s_d;
    logic       d_q,    d_d;
    logic [1:0] x_q,    x_d;
    logic [1:0] last_q, last_d;

    logic [1:0] sel;
    logic [1:0] idx;
    logic       found;
    logic       serve;
    logic [3:0] served;

    // Search order starts just after the last served channel and ends on it.
    always_comb begin
        sel   = last_q;
        idx   = last_q;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!found && pend_q[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        serve  = bus.en & found;
        served = serve ? (4'b0001 << sel) : 4'b0000;
    end

    always_comb begin
        pend_d = pend_q;
        dat_d  = dat_q;
        ovf_d  = ovf_q;
        s_d    = serve;
        d_d    = d_q;
        x_d    = x_q;
        last_d = last_q;

        for (int i = 0; i < 4; i++) begin
            if (served[i]) begin
                // A strobe on the served channel refills the slot being emptied.
                pend_d[i] = bus.v[i];
                if (bus.v[i]) begin
                    dat_d[i] = bus.a[i];
                end
            end else if (bus.v[i]) begin
                if (pend_q[i]) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    pend_d[i] = 1'b1;
                    dat_d[i]  = bus.a[i];
                end
            end
        end

        if (serve) begin
            d_d    = dat_q[sel];
            x_d    = sel;
            last_d = sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= 4'b0000;
            dat_q  <= 4'b0000;
            ovf_q  <= 4'b0000;
            s_q    <= 1'b0;
            d_q    <= 1'b0;
            x_q    <= 2'b00;
            last_q <= 2'b11;
        end else begin
            pend_q <= pend_d;
            dat_q  <= dat_d;
            ovf_q  <= ovf_d;
            s_q    <= s_d;
            d_q    <= d_d;
            x_q    <= x_d;
            last_q <= last_d;
        end
    end

    assign bus.d    = d_q;
    assign bus.x    = x_q;
    assign bus.s    = s_q;
    assign bus.busy = |pend_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_tdm_mux_4x2.sv
// Directed-vector bench for tdm_mux_4x2; expected values are hand-derived per scenario.
module tb_tdm_mux_4x2;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    tdm_mux_4x2_if bus ();

    tdm_mux_4x2 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        bus.a  = 4'b0000;
        bus.v  = 4'b0000;
        bus.en = 1'b1;
        step();
        rst    = 1'b0;
    endtask

    logic [3:0] pat;
    logic [3:0] dat_m;

    initial begin
        rst    = 1'b1;
        bus.a  = 4'b0000;
        bus.v  = 4'b0000;
        bus.en = 1'b1;
        step();
        chk("rst_s",    8'(bus.s),    8'h0);
        chk("rst_d",    8'(bus.d),    8'h0);
        chk("rst_x",    8'(bus.x),    8'h0);
        chk("rst_busy", 8'(bus.busy), 8'h0);
        chk("rst_ovf",  8'(bus.ovf),  8'h0);

        // Single channel: load ch2, served one edge later
        do_reset();
        bus.a = 4'b0100;
        bus.v = 4'b0100;
        step();
        chk("single_load_s",    8'(bus.s),    8'h0);
        chk("single_load_busy", 8'(bus.busy), 8'h1);
        bus.v = 4'b0000;
        step();
        chk("single_s",    8'(bus.s),    8'h1);
        chk("single_x",    8'(bus.x),    8'h2);
        chk("single_d",    8'(bus.d),    8'h1);
        chk("single_busy", 8'(bus.busy), 8'h0);
        step();
        chk("single_idle_s", 8'(bus.s), 8'h0);
        chk("single_hold_x", 8'(bus.x), 8'h2);
        chk("single_hold_d", 8'(bus.d), 8'h1);

        // Round robin from reset: channel 0 first, pointer wraps through 3
        do_reset();
        pat   = 4'b1010;
        bus.a = pat;
        bus.v = 4'b1111;
        step();
        bus.v = 4'b0000;
        bus.a = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_s", 8'(bus.s), 8'h1);
            chk("rr_x", 8'(bus.x), 8'(i));
            chk("rr_d", 8'(bus.d), 8'(pat[i]));
        end
        step();
        chk("rr_end_s",    8'(bus.s),    8'h0);
        chk("rr_end_busy", 8'(bus.busy), 8'h0);

        // Fairness: strobe only the channel being served so every buffer is refilled without overflow
        do_reset();
        pat   = 4'b1010;
        bus.a = pat;
        bus.v = 4'b1111;
        step();
        dat_m = pat;
        for (int c = 0; c < 8; c++) begin
            pat   = ~pat;
            bus.a = pat;
            bus.v = 4'b0001 << (c % 4);
            step();
            chk("fair_s", 8'(bus.s), 8'h1);
            chk("fair_x", 8'(bus.x), 8'(c % 4));
            chk("fair_d", 8'(bus.d), 8'(dat_m[c % 4]));
            dat_m[c % 4] = pat[c % 4];
        end
        bus.v = 4'b0000;
        chk("fair_ovf",  8'(bus.ovf),  8'h0);
        chk("fair_busy", 8'(bus.busy), 8'h1);

        // Overflow while disabled, then the original bit is sent
        do_reset();
        bus.en = 1'b0;
        bus.a  = 4'b0001;
        bus.v  = 4'b0001;
        step();
        chk("ovf_first", 8'(bus.ovf), 8'h0);
        bus.a  = 4'b0000;
        step();
        chk("ovf_set", 8'(bus.ovf), 8'h1);
        chk("ovf_s",   8'(bus.s),   8'h0);
        bus.v  = 4'b0000;
        bus.en = 1'b1;
        step();
        chk("ovf_tx_s", 8'(bus.s), 8'h1);
        chk("ovf_tx_x", 8'(bus.x), 8'h0);
        chk("ovf_tx_d", 8'(bus.d), 8'h1);
        step();
        chk("ovf_sticky", 8'(bus.ovf), 8'h1);
        chk("ovf_idle_s", 8'(bus.s),   8'h0);

        // Enable gating: ch1 and ch3 wait while en=0
        do_reset();
        bus.en = 1'b0;
        bus.a  = 4'b1010;
        bus.v  = 4'b1010;
        step();
        bus.v  = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("gate_s",    8'(bus.s),    8'h0);
            chk("gate_busy", 8'(bus.busy), 8'h1);
        end
        bus.en = 1'b1;
        step();
        chk("gate_s1", 8'(bus.s), 8'h1);
        chk("gate_x1", 8'(bus.x), 8'h1);
        step();
        chk("gate_s3", 8'(bus.s), 8'h1);
        chk("gate_x3", 8'(bus.x), 8'h3);
        step();
        chk("gate_end_s", 8'(bus.s), 8'h0);

        // Reset mid-stream discards pending data
        do_reset();
        bus.a = 4'b1111;
        bus.v = 4'b1111;
        step();
        bus.v = 4'b0000;
        step();
        chk("mid_x0", 8'(bus.x), 8'h0);
        step();
        chk("mid_x1", 8'(bus.x), 8'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_s",    8'(bus.s),    8'h0);
        chk("mid_rst_busy", 8'(bus.busy), 8'h0);
        chk("mid_rst_ovf",  8'(bus.ovf),  8'h0);
        bus.a = 4'b0100;
        bus.v = 4'b0100;
        step();
        bus.v = 4'b0000;
        step();
        chk("mid_after_s", 8'(bus.s), 8'h1);
        chk("mid_after_x", 8'(bus.x), 8'h2);
        chk("mid_after_d", 8'(bus.d), 8'h1);

        // Reset wins over strobes at the same edge, even into full buffers
        do_reset();
        bus.en = 1'b0;
        bus.a  = 4'b1111;
        bus.v  = 4'b1111;
        step();
        rst    = 1'b1;
        step();
        rst    = 1'b0;
        bus.v  = 4'b0000;
        bus.en = 1'b1;
        chk("prec_busy", 8'(bus.busy), 8'h0);
        chk("prec_ovf",  8'(bus.ovf),  8'h0);
        step();
        chk("prec_s", 8'(bus.s), 8'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
